// File: rtl/lnrv_icb_buf_if.sv
// ICB bus bundle. There is one command channel and one response channel.
// Master drives commands and accepts responses; slave does the reverse.
`timescale 1ns/1ps
interface lnrv_icb_buf_if #(
  parameter int unsigned P_ADDR_WIDTH = 32,
  parameter int unsigned P_DATA_WIDTH = 32
);
  logic                      cmd_vld;
  logic                      cmd_rdy;
  logic                      cmd_write;
  logic [P_ADDR_WIDTH-1:0]   cmd_addr;
  logic [P_DATA_WIDTH-1:0]   cmd_wdata;
  logic [P_DATA_WIDTH/8-1:0] cmd_wstrb;
  logic                      rsp_vld;
  logic                      rsp_rdy;
  logic                      rsp_err;
  logic [P_DATA_WIDTH-1:0]   rsp_rdata;

  modport master (
    output cmd_vld, cmd_write, cmd_addr, cmd_wdata, cmd_wstrb, rsp_rdy,
    input  cmd_rdy, rsp_vld, rsp_err, rsp_rdata
  );

  modport slave (
    input  cmd_vld, cmd_write, cmd_addr, cmd_wdata, cmd_wstrb, rsp_rdy,
    output cmd_rdy, rsp_vld, rsp_err, rsp_rdata
  );
endinterface

// File: rtl/lnrv_icb_buf.sv
// ICB buffer stage: a registered command FIFO and a registered response FIFO.
// An outstanding-transaction limit stops the response FIFO from overflowing.
`timescale 1ns/1ps
module lnrv_icb_buf #(
  parameter int unsigned P_ADDR_WIDTH = 32,
  parameter int unsigned P_DATA_WIDTH = 32,
  parameter int unsigned P_CMD_DEPTH  = 2,
  parameter int unsigned P_RSP_DEPTH  = 2
) (
  input  logic          clk,
  input  logic          reset_n,
  lnrv_icb_buf_if.slave  i_icb,
  lnrv_icb_buf_if.master o_icb
);

  localparam int unsigned STRB_W = P_DATA_WIDTH / 8;
  localparam int unsigned CMD_W  = 1 + P_ADDR_WIDTH + P_DATA_WIDTH + STRB_W;
  localparam int unsigned RSP_W  = 1 + P_DATA_WIDTH;
  localparam int unsigned CMD_PW = $clog2(P_CMD_DEPTH);
  localparam int unsigned RSP_PW = $clog2(P_RSP_DEPTH);
  localparam int unsigned OUT_W  = RSP_PW + 1;

  logic [CMD_W-1:0]  cmd_mem_q [P_CMD_DEPTH];
  logic [CMD_PW-1:0] cmd_wptr_q, cmd_wptr_d, cmd_rptr_q, cmd_rptr_d;
  logic [CMD_PW:0]   cmd_cnt_q, cmd_cnt_d;

  logic [RSP_W-1:0]  rsp_mem_q [P_RSP_DEPTH];
  logic [RSP_PW-1:0] rsp_wptr_q, rsp_wptr_d, rsp_rptr_q, rsp_rptr_d;
  logic [RSP_PW:0]   rsp_cnt_q, rsp_cnt_d;

  logic [OUT_W-1:0]  outst_q, outst_d;

  logic cmd_full_c, rsp_full_c;
  logic cmd_rdy_c, cmd_vld_c, rsp_rdy_c, rsp_vld_c;
  logic cmd_push_c, cmd_pop_c, rsp_push_c, rsp_pop_c;

  // Ready and valid come only from registered counts, so there is no combinational bypass.
  assign cmd_full_c = (cmd_cnt_q == (CMD_PW + 1)'(P_CMD_DEPTH));
  assign rsp_full_c = (rsp_cnt_q == (RSP_PW + 1)'(P_RSP_DEPTH));
  assign cmd_rdy_c  = !cmd_full_c && (outst_q < OUT_W'(P_RSP_DEPTH));
  assign cmd_vld_c  = (cmd_cnt_q != '0);
  assign rsp_rdy_c  = !rsp_full_c;
  assign rsp_vld_c  = (rsp_cnt_q != '0);

  assign cmd_push_c = i_icb.cmd_vld && cmd_rdy_c;
  assign cmd_pop_c  = cmd_vld_c && o_icb.cmd_rdy;
  assign rsp_push_c = o_icb.rsp_vld && rsp_rdy_c;
  assign rsp_pop_c  = rsp_vld_c && i_icb.rsp_rdy;

  assign i_icb.cmd_rdy = cmd_rdy_c;
  assign o_icb.cmd_vld = cmd_vld_c;
  assign {o_icb.cmd_write, o_icb.cmd_addr, o_icb.cmd_wdata, o_icb.cmd_wstrb} = cmd_mem_q[cmd_rptr_q];

  assign o_icb.rsp_rdy = rsp_rdy_c;
  assign i_icb.rsp_vld = rsp_vld_c;
  assign {i_icb.rsp_err, i_icb.rsp_rdata} = rsp_mem_q[rsp_rptr_q];

  always_comb begin
    cmd_wptr_d = cmd_wptr_q;
    cmd_rptr_d = cmd_rptr_q;
    rsp_wptr_d = rsp_wptr_q;
    rsp_rptr_d = rsp_rptr_q;
    if (cmd_push_c) cmd_wptr_d = cmd_wptr_q + CMD_PW'(1);
    if (cmd_pop_c)  cmd_rptr_d = cmd_rptr_q + CMD_PW'(1);
    if (rsp_push_c) rsp_wptr_d = rsp_wptr_q + RSP_PW'(1);
    if (rsp_pop_c)  rsp_rptr_d = rsp_rptr_q + RSP_PW'(1);
    cmd_cnt_d = cmd_cnt_q + (CMD_PW + 1)'(cmd_push_c) - (CMD_PW + 1)'(cmd_pop_c);
    rsp_cnt_d = rsp_cnt_q + (RSP_PW + 1)'(rsp_push_c) - (RSP_PW + 1)'(rsp_pop_c);
    // A command accept and a response return in the same cycle cancel each other.
    outst_d   = outst_q + OUT_W'(cmd_push_c) - OUT_W'(rsp_pop_c);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cmd_wptr_q <= '0;
      cmd_rptr_q <= '0;
      cmd_cnt_q  <= '0;
      rsp_wptr_q <= '0;
      rsp_rptr_q <= '0;
      rsp_cnt_q  <= '0;
      outst_q    <= '0;
    end else begin
      cmd_wptr_q <= cmd_wptr_d;
      cmd_rptr_q <= cmd_rptr_d;
      cmd_cnt_q  <= cmd_cnt_d;
      rsp_wptr_q <= rsp_wptr_d;
      rsp_rptr_q <= rsp_rptr_d;
      rsp_cnt_q  <= rsp_cnt_d;
      outst_q    <= outst_d;
    end
  end

  // Storage arrays have no reset; the head is only used while the FIFO is non-empty.
  always_ff @(posedge clk) begin
    if (cmd_push_c)
      cmd_mem_q[cmd_wptr_q] <= {i_icb.cmd_write, i_icb.cmd_addr, i_icb.cmd_wdata, i_icb.cmd_wstrb};
    if (rsp_push_c)
      rsp_mem_q[rsp_wptr_q] <= {o_icb.rsp_err, o_icb.rsp_rdata};
  end

endmodule

// File: tb/tb_lnrv_icb_buf.sv
// Directed bench for lnrv_icb_buf using the default two-entry FIFOs.
// Expected values are constants or come from the bench's own response model.
`timescale 1ns/1ps
module tb_lnrv_icb_buf;

  logic clk;
  logic reset_n;
  int   errors = 0;
  int   checks = 0;

  lnrv_icb_buf_if #(.P_ADDR_WIDTH(32), .P_DATA_WIDTH(32)) up ();
  lnrv_icb_buf_if #(.P_ADDR_WIDTH(32), .P_DATA_WIDTH(32)) dn ();

  lnrv_icb_buf #(
    .P_ADDR_WIDTH(32), .P_DATA_WIDTH(32), .P_CMD_DEPTH(2), .P_RSP_DEPTH(2)
  ) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .i_icb   (up),
    .o_icb   (dn)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic put_cmd(input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                         input logic [3:0] strb);
    up.cmd_vld   = 1'b1;
    up.cmd_write = wr;
    up.cmd_addr  = addr;
    up.cmd_wdata = wdata;
    up.cmd_wstrb = strb;
  endtask

  function automatic logic [31:0] rd_model(input logic [31:0] addr);
    case (addr)
      32'h0:   return 32'h11;
      32'h4:   return 32'h22;
      32'h8:   return 32'h33;
      default: return 32'hBAD0BAD0;
    endcase
  endfunction

  logic [31:0] pend[$];
  logic [31:0] exp_rd [3];

  initial begin
    reset_n      = 1'b0;
    up.cmd_vld   = 1'b0;
    up.cmd_write = 1'b0;
    up.cmd_addr  = '0;
    up.cmd_wdata = '0;
    up.cmd_wstrb = '0;
    up.rsp_rdy   = 1'b0;
    dn.cmd_rdy   = 1'b0;
    dn.rsp_vld   = 1'b0;
    dn.rsp_err   = 1'b0;
    dn.rsp_rdata = '0;
    exp_rd[0] = 32'h11;
    exp_rd[1] = 32'h22;
    exp_rd[2] = 32'h33;

    // Values held while reset is asserted
    #2;
    check("rst_o_cmd_vld", dn.cmd_vld, 0);
    check("rst_i_rsp_vld", up.rsp_vld, 0);
    check("rst_i_cmd_rdy", up.cmd_rdy, 1);
    check("rst_o_rsp_rdy", dn.rsp_rdy, 1);
    check("rst_outst", dut.outst_q, 0);
    #20 reset_n = 1'b1;
    step();

    // Single write: one cycle of latency on the command path and one on the response path
    dn.cmd_rdy = 1'b1;
    put_cmd(1'b1, 32'h100, 32'hDEADBEEF, 4'hF);
    check("wr_pre_vld", dn.cmd_vld, 0);
    step();
    up.cmd_vld = 1'b0;
    check("wr_o_vld", dn.cmd_vld, 1);
    check("wr_o_write", dn.cmd_write, 1);
    check("wr_o_addr", dn.cmd_addr, 32'h100);
    check("wr_o_wdata", dn.cmd_wdata, 32'hDEADBEEF);
    check("wr_o_wstrb", dn.cmd_wstrb, 4'hF);
    step();
    check("wr_o_popped", dn.cmd_vld, 0);
    dn.rsp_vld = 1'b1; dn.rsp_err = 1'b0; dn.rsp_rdata = 32'h0;
    step();
    dn.rsp_vld = 1'b0;
    check("wr_rsp_vld", up.rsp_vld, 1);
    check("wr_rsp_err", up.rsp_err, 0);
    up.rsp_rdy = 1'b1;
    step();
    up.rsp_rdy = 1'b0;
    check("wr_rsp_popped", up.rsp_vld, 0);

    // Back-pressure: three offered commands, two accepted; the read keeps its strobes
    dn.cmd_rdy = 1'b0;
    for (int k = 0; k < 3; k++) begin
      put_cmd(1'b0, 32'hA0 + 32'(k * 4), 32'h0, 4'h5);
      check($sformatf("bp_rdy%0d", k), up.cmd_rdy, (k < 2) ? 1 : 0);
      step();
    end
    up.cmd_vld = 1'b0;
    check("bp_rdy_after", up.cmd_rdy, 0);
    dn.cmd_rdy = 1'b1;
    check("bp_fwd0_vld", dn.cmd_vld, 1);
    check("bp_fwd0_addr", dn.cmd_addr, 32'hA0);
    check("bp_fwd0_wstrb", dn.cmd_wstrb, 4'h5);
    step();
    check("bp_fwd1_addr", dn.cmd_addr, 32'hA4);
    step();
    check("bp_drained", dn.cmd_vld, 0);

    // Outstanding limit reached while the command FIFO is empty
    check("os_outst2", dut.outst_q, 2);
    check("os_rdy0", up.cmd_rdy, 0);
    dn.rsp_vld = 1'b1; dn.rsp_err = 1'b1; dn.rsp_rdata = 32'hA1;
    step();
    dn.rsp_err = 1'b0; dn.rsp_rdata = 32'hA2;
    step();
    dn.rsp_vld = 1'b0;
    check("os_rsp0_data", up.rsp_rdata, 32'hA1);
    check("os_rsp0_err", up.rsp_err, 1);
    check("os_rdy_still0", up.cmd_rdy, 0);
    up.rsp_rdy = 1'b1;
    step();
    up.rsp_rdy = 1'b0;
    check("os_rdy1", up.cmd_rdy, 1);
    check("os_rsp1_data", up.rsp_rdata, 32'hA2);

    // Command accept and response return in the same cycle
    put_cmd(1'b0, 32'h200, 32'h0, 4'h0);
    up.rsp_rdy = 1'b1;
    step();
    up.cmd_vld = 1'b0;
    up.rsp_rdy = 1'b0;
    check("sim_outst1", dut.outst_q, 1);
    check("sim_rsp_empty", up.rsp_vld, 0);
    check("sim_o_vld", dn.cmd_vld, 1);
    check("sim_o_addr", dn.cmd_addr, 32'h200);
    step();
    dn.rsp_vld = 1'b1; dn.rsp_rdata = 32'h55;
    step();
    dn.rsp_vld = 1'b0;
    check("sim_rsp_data", up.rsp_rdata, 32'h55);
    up.rsp_rdy = 1'b1;
    step();
    up.rsp_rdy = 1'b0;
    check("sim_outst0", dut.outst_q, 0);

    // Streaming reads with a randomly stalled upstream response ready
    begin
      int ni = 0;
      int nr = 0;
      int budget = 0;
      logic up_hs, dn_cmd_hs, dn_rsp_hs, up_rsp_hs;
      logic [31:0] fwd_addr, got_rd;
      while (nr < 3 && budget < 200) begin
        budget++;
        if (ni < 3) put_cmd(1'b0, 32'(ni * 4), 32'h0, 4'h0);
        else up.cmd_vld = 1'b0;
        dn.cmd_rdy = 1'b1;
        dn.rsp_vld = (pend.size() > 0);
        dn.rsp_err = 1'b0;
        dn.rsp_rdata = (pend.size() > 0) ? pend[0] : 32'h0;
        up.rsp_rdy = 1'($urandom_range(0, 1));
        #1;
        up_hs     = up.cmd_vld && up.cmd_rdy;
        dn_cmd_hs = dn.cmd_vld && dn.cmd_rdy;
        dn_rsp_hs = dn.rsp_vld && dn.rsp_rdy;
        up_rsp_hs = up.rsp_vld && up.rsp_rdy;
        fwd_addr  = dn.cmd_addr;
        got_rd    = up.rsp_rdata;
        step();
        if (up_hs) ni++;
        if (dn_rsp_hs) void'(pend.pop_front());
        if (dn_cmd_hs) pend.push_back(rd_model(fwd_addr));
        if (up_rsp_hs) begin
          check($sformatf("rd_data%0d", nr), got_rd, exp_rd[nr]);
          nr++;
        end
      end
      up.cmd_vld = 1'b0;
      up.rsp_rdy = 1'b0;
      dn.rsp_vld = 1'b0;
      check("rd_count", 32'(nr), 3);
      step();
      step();
      check("rd_no_dup", up.rsp_vld, 0);
      check("rd_outst0", dut.outst_q, 0);
    end

    // Reset while commands and a response are queued
    dn.cmd_rdy = 1'b0;
    dn.rsp_vld = 1'b1; dn.rsp_rdata = 32'h77;
    step();
    dn.rsp_vld = 1'b0;
    put_cmd(1'b1, 32'h300, 32'h1, 4'h1);
    step();
    put_cmd(1'b1, 32'h304, 32'h2, 4'h2);
    step();
    up.cmd_vld = 1'b0;
    check("mr_pre_o_vld", dn.cmd_vld, 1);
    check("mr_pre_rsp_vld", up.rsp_vld, 1);
    #2 reset_n = 1'b0;
    #1;
    check("mr_o_vld", dn.cmd_vld, 0);
    check("mr_rsp_vld", up.rsp_vld, 0);
    #2 reset_n = 1'b1;
    step();
    check("mr_post_rdy", up.cmd_rdy, 1);
    check("mr_post_o_vld", dn.cmd_vld, 0);
    check("mr_post_rsp_vld", up.rsp_vld, 0);
    check("mr_post_outst", dut.outst_q, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
